// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential packed-BCD to unsigned binary converter.
// Reverse double-dabble, one result bit per clock. Words with a nibble above
// 9 are flagged through digit_error_o instead of being converted.
module bcd_to_binary #(
    parameter int DIGITS    = 3,
    parameter int BIN_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [4*DIGITS-1:0]   bcd_in_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [BIN_WIDTH-1:0]  bin_out_o,
    output logic                  digit_error_o,
    output logic                  busy_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_WIDTH;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t               state_q;
    logic [SR_W-1:0]      sr_q;
    logic [SR_W-1:0]      sr_shift_s;
    logic [SR_W-1:0]      sr_d;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic                 digit_error_q;
    logic [BIN_WIDTH-1:0] bin_out_q;
    logic                 bad_digit_s;

    // True when any nibble of the word is not a decimal digit.
    function automatic logic has_bad_digit(input logic [BCD_W-1:0] word);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (word[4*i +: 4] > 4'd9);
        end
        return bad;
    endfunction

    // One reverse double-dabble step: shift right, then pull every BCD nibble
    // that landed at 8 or more back down by 3.
    always_comb begin
        sr_shift_s  = sr_q >> 1;
        sr_d        = sr_shift_s;
        count_d     = count_q + CNT_W'(1);
        bad_digit_s = has_bad_digit(bcd_in_i);
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_shift_s[BIN_WIDTH + 4*i +: 4] >= 4'd8) begin
                sr_d[BIN_WIDTH + 4*i +: 4] = sr_shift_s[BIN_WIDTH + 4*i +: 4] - 4'd3;
            end else begin
                sr_d[BIN_WIDTH + 4*i +: 4] = sr_shift_s[BIN_WIDTH + 4*i +: 4];
            end
        end
    end

    // Control FSM with registered handshake outputs and result holding.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            sr_q          <= '0;
            count_q       <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            digit_error_q <= 1'b0;
            bin_out_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        if (bad_digit_s) begin
                            // Reject without converting: result is presented next cycle.
                            bin_out_q     <= '0;
                            digit_error_q <= 1'b1;
                            out_valid_q   <= 1'b1;
                            state_q       <= ST_DONE;
                        end else begin
                            sr_q    <= {bcd_in_i, {BIN_WIDTH{1'b0}}};
                            count_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_CONVERT;
                        end
                    end else begin
                        // in_ready comes up one cycle after reset or after a transfer.
                        in_ready_q <= 1'b1;
                    end
                end
                ST_CONVERT: begin
                    sr_q    <= sr_d;
                    count_q <= count_d;
                    if (count_q == LAST_CNT) begin
                        bin_out_q     <= sr_d[BIN_WIDTH-1:0];
                        digit_error_q <= 1'b0;
                        busy_q        <= 1'b0;
                        out_valid_q   <= 1'b1;
                        state_q       <= ST_DONE;
                    end else begin
                        state_q <= ST_CONVERT;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign busy_o        = busy_q;
    assign digit_error_o = digit_error_q;
    assign bin_out_o     = bin_out_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: scoreboard fed at accept time and
// drained at output transfer, plus directed checks and two parameter variants.
module tb_bcd_to_binary;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready_o;
    logic [11:0] bcd_in;
    logic        out_valid_o;
    logic        out_ready;
    logic [9:0]  bin_out_o;
    logic        digit_error_o;
    logic        busy_o;

    logic        v1_valid, v1_ready, v1_ov, v1_ordy, v1_err, v1_busy;
    logic [3:0]  v1_bcd, v1_bin;
    logic        v4_valid, v4_ready, v4_ov, v4_ordy, v4_err, v4_busy;
    logic [15:0] v4_bcd;
    logic [13:0] v4_bin;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic sweep_mode = 1'b0;

    typedef struct {
        logic [31:0] bin;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb_q[$];

    bcd_to_binary #(.DIGITS(3), .BIN_WIDTH(10)) dut (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .bcd_in_i(bcd_in), .out_valid_o(out_valid_o), .out_ready_i(out_ready),
        .bin_out_o(bin_out_o), .digit_error_o(digit_error_o), .busy_o(busy_o));

    bcd_to_binary #(.DIGITS(1), .BIN_WIDTH(4)) dut1 (
        .clk_i(clk), .reset_i(reset), .in_valid_i(v1_valid), .in_ready_o(v1_ready),
        .bcd_in_i(v1_bcd), .out_valid_o(v1_ov), .out_ready_i(v1_ordy),
        .bin_out_o(v1_bin), .digit_error_o(v1_err), .busy_o(v1_busy));

    bcd_to_binary #(.DIGITS(4), .BIN_WIDTH(14)) dut4 (
        .clk_i(clk), .reset_i(reset), .in_valid_i(v4_valid), .in_ready_o(v4_ready),
        .bcd_in_i(v4_bcd), .out_valid_o(v4_ov), .out_ready_i(v4_ordy),
        .bin_out_o(v4_bin), .digit_error_o(v4_err), .busy_o(v4_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Expected response from decimal digit arithmetic; lat is in edges from accept.
    function automatic exp_t model(input logic [11:0] b);
        exp_t e;
        int d2, d1, d0;
        d2 = int'(b[11:8]);
        d1 = int'(b[7:4]);
        d0 = int'(b[3:0]);
        if (d2 > 9 || d1 > 9 || d0 > 9) begin
            e.bin = 32'd0;
            e.err = 1'b1;
            e.lat = 0;
        end else begin
            e.bin = 32'(d2 * 100 + d1 * 10 + d0);
            e.err = 1'b0;
            e.lat = 10;
        end
        e.acc = 0;
        return e;
    endfunction

    // Monitor: push at accept, pop and compare at output transfer.
    int   rise_cyc = 0;
    int   prev_acc = 0;
    logic have_prev = 1'b0;
    logic ov_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb_q.delete();
            ov_prev   = 1'b0;
            have_prev = 1'b0;
        end else begin
            if (out_valid_o && !ov_prev) rise_cyc = cyc;
            ov_prev = out_valid_o;
            if (!sweep_mode) have_prev = 1'b0;
            if (in_valid && in_ready_o) begin
                e = model(bcd_in);
                e.acc = cyc + 1;
                sb_q.push_back(e);
                if (sweep_mode && have_prev) check_eq("acc_gap", 32'(cyc + 1 - prev_acc), 32'd12);
                prev_acc  = cyc + 1;
                have_prev = 1'b1;
            end
            if (out_valid_o && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("bin_out", 32'(bin_out_o), e.bin);
                    check_eq("digit_error", 32'(digit_error_o), 32'(e.err));
                    check_eq("latency", 32'(rise_cyc - e.acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] v);
        int n;
        bcd_in   = v;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready_o && n < 100) begin
            step();
            n++;
        end
        check_eq("accept", 32'(in_ready_o), 32'd1);
        step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid_o) && n < 100) begin
            step();
            n++;
        end
        check_eq("drain", 32'(sb_q.size() == 0 && !out_valid_o), 32'd1);
    endtask

    initial begin
        logic [11:0] dir_vals [6];
        logic        any_ov;
        int          n;
        dir_vals = '{12'h999, 12'h000, 12'h255, 12'h100, 12'h1A5, 12'hF00};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; bcd_in = 12'h000;
        v1_valid = 1'b0; v1_bcd = 4'h0; v1_ordy = 1'b1;
        v4_valid = 1'b0; v4_bcd = 16'h0000; v4_ordy = 1'b1;
        step(); step();
        check_eq("rst_in_ready", 32'(in_ready_o), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_bin", 32'(bin_out_o), 32'd0);
        check_eq("rst_err", 32'(digit_error_o), 32'd0);
        reset = 1'b0;
        step();
        check_eq("rst_ready_rise", 32'(in_ready_o), 32'd1);

        // Directed legal and illegal words, one at a time.
        for (int i = 0; i < 6; i++) begin
            send(dir_vals[i]);
            in_valid = 1'b0;
            check_eq("busy_after_accept", 32'(busy_o), 32'(!model(dir_vals[i]).err));
            drain();
        end

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send(12'h512);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_o && n < 40) begin
            step();
            n++;
        end
        check_eq("bp_ov_rise", 32'(out_valid_o), 32'd1);
        for (int i = 0; i < 6; i++) begin
            bcd_in   = 12'($urandom);
            in_valid = 1'b1;
            step();
            check_eq("bp_bin_hold", 32'(bin_out_o), 32'd512);
            check_eq("bp_ov_hold", 32'(out_valid_o), 32'd1);
            check_eq("bp_in_ready", 32'(in_ready_o), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq("bp_xfer", 32'(out_valid_o), 32'd0);
        step();
        check_eq("bp_ready_back", 32'(in_ready_o), 32'd1);

        // Reset in the middle of a conversion discards it.
        send(12'h999);
        in_valid = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step(); step();
        check_eq("mid_rst_in_ready", 32'(in_ready_o), 32'd0);
        check_eq("mid_rst_ov", 32'(out_valid_o), 32'd0);
        check_eq("mid_rst_busy", 32'(busy_o), 32'd0);
        check_eq("mid_rst_bin", 32'(bin_out_o), 32'd0);
        check_eq("mid_rst_err", 32'(digit_error_o), 32'd0);
        reset = 1'b0;
        step();
        check_eq("mid_rst_ready", 32'(in_ready_o), 32'd1);
        any_ov = 1'b0;
        repeat (15) begin
            if (out_valid_o) any_ov = 1'b1;
            step();
        end
        check_eq("mid_rst_no_ov", 32'(any_ov), 32'd0);

        // Exhaustive back-to-back sweep of every legal word.
        sweep_mode = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            send({4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)});
        end
        in_valid = 1'b0;
        drain();
        sweep_mode = 1'b0;

        // DIGITS=1, BIN_WIDTH=4 variant.
        v1_bcd = 4'h9; v1_valid = 1'b1;
        n = 0;
        while (!v1_ready && n < 20) begin
            step();
            n++;
        end
        step();
        v1_valid = 1'b0;
        n = 0;
        while (!v1_ov && n < 40) begin
            step();
            n++;
        end
        check_eq("v1_latency", 32'(n), 32'd4);
        check_eq("v1_bin", 32'(v1_bin), 32'd9);
        check_eq("v1_err", 32'(v1_err), 32'd0);

        // DIGITS=4, BIN_WIDTH=14 variant.
        v4_bcd = 16'h9999; v4_valid = 1'b1;
        n = 0;
        while (!v4_ready && n < 20) begin
            step();
            n++;
        end
        step();
        v4_valid = 1'b0;
        n = 0;
        while (!v4_ov && n < 40) begin
            step();
            n++;
        end
        check_eq("v4_latency", 32'(n), 32'd14);
        check_eq("v4_bin", 32'(v4_bin), 32'd9999);
        check_eq("v4_err", 32'(v4_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
